alarm_digit_setter: RTL and testbench

- Parametrised successor to the 4-digit alarm setter: holds NUM_DIGITS BCD-style alarm digits, each with its own maximum value.
- Selected digit steps up or down on button presses. Holding a button auto-repeats.
- Fully synchronous to the 100 MHz system clock; inc/dec buttons arrive already debounced.
- Digit outputs feed the seven-segment mux and the alarm comparator.

---
 rtl/alarm_digit_setter.sv | 173 +++++++++++++++++
 tb/tb_alarm_digit_setter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alarm_digit_setter.sv
// Parametrised alarm digit setter: per-digit wrap limits, select-driven up/down stepping with hold auto-repeat.
// Optional build macro ALARM_CARRY_EN ripples wrap carries/borrows into the next digit.
module alarm_digit_setter #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DIGIT_MAX = 16'h5959,
    parameter int REPEAT_DLY = 50_000_000,
    parameter int REPEAT_RATE = 20_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clearAlarm,
    input  logic                           incBtn,
    input  logic                           decBtn,
    input  logic [NUM_DIGITS-1:0]          SevSegSelect,
    output logic [NUM_DIGITS*DIGIT_W-1:0]  binDigits,
    output logic                           selError,
    output logic                           repeating
);
    localparam int MAX_CNT = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CW = $clog2(MAX_CNT) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} state_t;

    state_t                        state_r;
    logic [CW-1:0]                 cnt_r;
    logic                          dir_r;
    logic                          incHist_r;
    logic                          decHist_r;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_r;
    logic                          selError_r;
    logic                          repeating_r;

    logic                          incReq_s;
    logic                          decReq_s;
    logic                          selOk_s;
    logic                          sameReq_s;
    logic                          fire_s;
    logic                          stepInc_s;
    logic                          stepDec_s;
    logic                          carry_s;
    logic [NUM_DIGITS*DIGIT_W-1:0] digitsNext_s;

    // One step of a single digit; anything at or above its max counts as wrapping.
    function automatic logic [DIGIT_W-1:0] stepDigit(input logic [DIGIT_W-1:0] cur,
                                                     input logic [DIGIT_W-1:0] mx,
                                                     input logic up);
        if (up) begin
            stepDigit = (cur >= mx) ? {DIGIT_W{1'b0}} : cur + {{(DIGIT_W-1){1'b0}}, 1'b1};
        end else begin
            stepDigit = ((cur == {DIGIT_W{1'b0}}) || (cur > mx)) ? mx
                                                                 : cur - {{(DIGIT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic digitWraps(input logic [DIGIT_W-1:0] cur,
                                        input logic [DIGIT_W-1:0] mx,
                                        input logic up);
        digitWraps = up ? (cur >= mx) : ((cur == {DIGIT_W{1'b0}}) || (cur > mx));
    endfunction

    // Request decode and step timing for the current state.
    always_comb begin
        incReq_s  = incBtn & ~decBtn;
        decReq_s  = decBtn & ~incBtn;
        selOk_s   = $onehot(SevSegSelect);
        sameReq_s = dir_r ? incReq_s : decReq_s;
        fire_s    = 1'b0;
        stepInc_s = 1'b0;
        stepDec_s = 1'b0;
        case (state_r)
            IDLE: begin
                fire_s    = (incReq_s & ~incHist_r) | (decReq_s & ~decHist_r);
                stepInc_s = fire_s & incReq_s;
                stepDec_s = fire_s & decReq_s;
            end
            HOLD: begin
                fire_s    = sameReq_s && (cnt_r == CW'(REPEAT_DLY - 1));
                stepInc_s = fire_s & dir_r;
                stepDec_s = fire_s & ~dir_r;
            end
            REPEAT: begin
                fire_s    = sameReq_s && (cnt_r == CW'(REPEAT_RATE - 1));
                stepInc_s = fire_s & dir_r;
                stepDec_s = fire_s & ~dir_r;
            end
            default: begin
                fire_s    = 1'b0;
                stepInc_s = 1'b0;
                stepDec_s = 1'b0;
            end
        endcase
    end

    // Next digit values; with carry enabled a wrap ripples upward through the chain.
    always_comb begin
        digitsNext_s = digits_r;
        carry_s      = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (selOk_s && (stepInc_s || stepDec_s) && (SevSegSelect[i] || carry_s)) begin
                digitsNext_s[i*DIGIT_W +: DIGIT_W] = stepDigit(digits_r[i*DIGIT_W +: DIGIT_W],
                                                               DIGIT_MAX[i*DIGIT_W +: DIGIT_W], stepInc_s);
`ifdef ALARM_CARRY_EN
                carry_s = digitWraps(digits_r[i*DIGIT_W +: DIGIT_W],
                                     DIGIT_MAX[i*DIGIT_W +: DIGIT_W], stepInc_s);
`else
                carry_s = 1'b0;
`endif
            end else begin
                carry_s = 1'b0;
            end
        end
    end

    // Digit registers, status flags and the hold/repeat FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            dir_r       <= 1'b0;
            incHist_r   <= 1'b0;
            decHist_r   <= 1'b0;
            digits_r    <= '0;
            selError_r  <= 1'b0;
            repeating_r <= 1'b0;
        end else begin
            // History tracks requests even through a clear so a held button needs a re-press.
            incHist_r  <= incReq_s;
            decHist_r  <= decReq_s;
            selError_r <= ~selOk_s;
            if (clearAlarm) begin
                digits_r    <= '0;
                state_r     <= IDLE;
                cnt_r       <= '0;
                repeating_r <= 1'b0;
            end else begin
                digits_r <= digitsNext_s;
                case (state_r)
                    IDLE: begin
                        cnt_r       <= '0;
                        repeating_r <= 1'b0;
                        if (fire_s) begin
                            state_r <= HOLD;
                            dir_r   <= incReq_s;
                        end
                    end
                    HOLD, REPEAT: begin
                        if (!sameReq_s) begin
                            state_r     <= IDLE;
                            cnt_r       <= '0;
                            repeating_r <= 1'b0;
                        end else if (fire_s) begin
                            state_r     <= REPEAT;
                            cnt_r       <= '0;
                            repeating_r <= 1'b1;
                        end else if (cnt_r != {CW{1'b1}}) begin
                            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_r     <= IDLE;
                        cnt_r       <= '0;
                        repeating_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign binDigits = digits_r;
    assign selError  = selError_r;
    assign repeating = repeating_r;
endmodule

// File: tb/tb_alarm_digit_setter.sv
// Scoreboard bench for alarm_digit_setter with short repeat timing (delay 8, rate 4).
module tb_alarm_digit_setter;
    logic        clk = 1'b0;
    logic        reset;
    logic        clearAlarm;
    logic        incBtn;
    logic        decBtn;
    logic [3:0]  SevSegSelect;
    logic [15:0] binDigits;
    logic        selError;
    logic        repeating;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        string       nm;
        logic [15:0] d;
        logic        se;
        logic        rp;
    } exp_t;
    exp_t q[$];

    alarm_digit_setter #(
        .NUM_DIGITS(4), .DIGIT_W(4), .DIGIT_MAX(16'h5959),
        .REPEAT_DLY(8), .REPEAT_RATE(4)
    ) dut (
        .clk(clk), .reset(reset), .clearAlarm(clearAlarm),
        .incBtn(incBtn), .decBtn(decBtn), .SevSegSelect(SevSegSelect),
        .binDigits(binDigits), .selError(selError), .repeating(repeating)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due by this cycle, sampled mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (binDigits !== e.d || selError !== e.se || repeating !== e.rp) begin
                bad++;
                $display("FAIL %s @cyc%0d: got digits=%h selError=%b repeating=%b, want digits=%h selError=%b repeating=%b",
                         e.nm, cyc, binDigits, selError, repeating, e.d, e.se, e.rp);
            end
        end
    end

    // Queue the state expected after the next clock edge, then advance one cycle.
    task automatic go(input string nm, input logic [15:0] d, input logic se, input logic rp);
        exp_t e;
        e.cyc = cyc + 1;
        e.nm  = nm;
        e.d   = d;
        e.se  = se;
        e.rp  = rp;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input string nm, input logic up, input logic [15:0] d);
        if (up) incBtn = 1'b1; else decBtn = 1'b1;
        go(nm, d, 1'b0, 1'b0);
        incBtn = 1'b0;
        decBtn = 1'b0;
        go({nm, "_rel"}, d, 1'b0, 1'b0);
    endtask

    initial begin
        int steps;
        reset = 1'b1;
        clearAlarm = 1'b0;
        incBtn = 1'b0;
        decBtn = 1'b0;
        SevSegSelect = 4'b0001;
        #2;
        go("reset0", 16'h0000, 1'b0, 1'b0);
        go("reset1", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
`ifdef ALARM_CARRY_EN
        pulse("borrow_chain", 1'b0, 16'h5959);
        SevSegSelect = 4'b1000;
        pulse("top_dec1", 1'b0, 16'h4959);
        pulse("top_dec2", 1'b0, 16'h3959);
        pulse("top_dec3", 1'b0, 16'h2959);
        pulse("top_dec4", 1'b0, 16'h1959);
        pulse("top_dec5", 1'b0, 16'h0959);
        SevSegSelect = 4'b0001;
        pulse("carry_chain", 1'b1, 16'h1000);
        SevSegSelect = 4'b1000;
        pulse("top_dec_nowrap", 1'b0, 16'h0000);
        pulse("top_wrap_no_carry", 1'b0, 16'h5000);
`else
        // Ten single pulses on digit 0: 1..9 then wrap to 0.
        for (int p = 1; p <= 10; p++) begin
            logic [15:0] v;
            v = 16'(p % 10);
            pulse("inc_pulse", 1'b1, v);
        end
        SevSegSelect = 4'b0010;
        pulse("dec_wrap_d1", 1'b0, 16'h0050);
        pulse("dec_d1", 1'b0, 16'h0040);

        // Hold inc for 30 cycles: steps at +0,+8,+12,...,+28.
        SevSegSelect = 4'b0001;
        incBtn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            steps = 1 + ((k >= 8) ? 1 + (k - 8) / 4 : 0);
            go("hold_repeat", 16'h0040 | 16'(steps), 1'b0, (k >= 8) ? 1'b1 : 1'b0);
        end
        incBtn = 1'b0;
        go("hold_release", 16'h0047, 1'b0, 1'b0);

        incBtn = 1'b1;
        decBtn = 1'b1;
        go("both_btns", 16'h0047, 1'b0, 1'b0);
        go("both_btns_hold", 16'h0047, 1'b0, 1'b0);
        incBtn = 1'b0;
        decBtn = 1'b0;
        go("both_release", 16'h0047, 1'b0, 1'b0);

        SevSegSelect = 4'b0011;
        incBtn = 1'b1;
        go("multihot_press", 16'h0047, 1'b1, 1'b0);
        incBtn = 1'b0;
        go("multihot_rel", 16'h0047, 1'b1, 1'b0);
        SevSegSelect = 4'b0000;
        go("zero_sel", 16'h0047, 1'b1, 1'b0);
        SevSegSelect = 4'b0001;
        go("sel_ok", 16'h0047, 1'b0, 1'b0);

        // Clear while repeating: held button must not step again until re-pressed.
        incBtn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            go("pre_clear_hold", (k >= 8) ? 16'h0049 : 16'h0048, 1'b0, (k >= 8) ? 1'b1 : 1'b0);
        end
        clearAlarm = 1'b1;
        go("clear", 16'h0000, 1'b0, 1'b0);
        clearAlarm = 1'b0;
        for (int k = 0; k < 12; k++) go("held_after_clear", 16'h0000, 1'b0, 1'b0);
        incBtn = 1'b0;
        go("clear_release", 16'h0000, 1'b0, 1'b0);
        pulse("repress_after_clear", 1'b1, 16'h0001);

        // Reset mid-hold, button released as reset drops.
        incBtn = 1'b1;
        for (int k = 0; k < 9; k++) begin
            go("pre_reset_hold", (k >= 8) ? 16'h0003 : 16'h0002, 1'b0, (k >= 8) ? 1'b1 : 1'b0);
        end
        reset = 1'b1;
        go("reset_mid_hold", 16'h0000, 1'b0, 1'b0);
        go("reset_mid_hold2", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        incBtn = 1'b0;
        for (int k = 0; k < 10; k++) go("after_reset_idle", 16'h0000, 1'b0, 1'b0);
        pulse("repress_after_reset", 1'b1, 16'h0001);
`endif
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
